// File: rtl/cnu_f1_multi.sv
// cnu_f1_multi -- first-stage (F1) check-node datapath for the IB-LDPC decoder.
//
// Serves CNU_NUM check nodes of degree CN_DEG per cycle. Each CNU does two
// lookups, {t_a, v2c[SEL_A]} and {t_b, v2c[SEL_B]}, into a multi-frame LUT.
// The full V2C vector and the frame tag are delayed alongside, so F2 sees them
// aligned with the lookup results. An update FSM reloads one LUT frame in place.
// While it runs, in_ready is held low.
//
// Ports:
//   read_clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready      input handshake (in_ready high only in IDLE)
//   in_frame               LUT frame used for this sample
//   t_a_in, t_b_in         partial-t per CNU (CNU c at slice c)
//   v2c_in                 V2C messages (CNU c, edge e at slice c*CN_DEG+e)
//   out_valid, out_frame   output strobe and forwarded frame tag
//   t_a_out, t_b_out       LUT results per CNU
//   v2c_out                delayed V2C vector
//   upd_start/upd_frame    begin reload of a frame
//   upd_we/upd_data        one LUT word per strobe, in address order
//   upd_busy, upd_done     load in progress / one-cycle completion pulse
//   lut_loaded             per-frame fully-written flag
//   frame_err              sticky: sample accepted on an unloaded frame

// Per-CNU delay line. Stage 1 captures the LUT read data (the LUT register).
// Later stages only advance when the stage before them holds a valid sample.
// The output therefore keeps its last value across bubbles.
module cnu_f1_lane #(
   parameter int QUAN_SIZE = 4,
   parameter int CN_DEG    = 6,
   parameter int STAGES    = 3
) (
   input  logic                        read_clk,
   input  logic                        rst,
   input  logic [STAGES:1]             stage_en,
   input  logic [QUAN_SIZE-1:0]        lut_a,
   input  logic [QUAN_SIZE-1:0]        lut_b,
   input  logic [CN_DEG*QUAN_SIZE-1:0] v2c,
   output logic [QUAN_SIZE-1:0]        t_a,
   output logic [QUAN_SIZE-1:0]        t_b,
   output logic [CN_DEG*QUAN_SIZE-1:0] v2c_d
);
   localparam int DW = (CN_DEG + 2) * QUAN_SIZE;

   logic [STAGES:1][DW-1:0] d_q;
   logic [STAGES:1][DW-1:0] d_in;

   always_comb begin
      d_in    = '0;
      d_in[1] = {lut_a, lut_b, v2c};
      for (int i = 2; i <= STAGES; i++) d_in[i] = d_q[i-1];
   end

   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         d_q <= '0;
      end else begin
         for (int i = 1; i <= STAGES; i++)
            if (stage_en[i]) d_q[i] <= d_in[i];
      end
   end

   assign {t_a, t_b, v2c_d} = d_q[STAGES];
endmodule

module cnu_f1_multi #(
   parameter int QUAN_SIZE       = 4,
   parameter int CNU_NUM         = 2,
   parameter int CN_DEG          = 6,
   parameter int SEL_A           = 2,
   parameter int SEL_B           = 5,
   parameter int PIPELINE_DEPTH  = 3,
   parameter int MULTI_FRAME_NUM = 2,
   parameter int FRAME_W         = 1
) (
   input  logic                                read_clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [FRAME_W-1:0]                  in_frame,
   input  logic [CNU_NUM*QUAN_SIZE-1:0]        t_a_in,
   input  logic [CNU_NUM*QUAN_SIZE-1:0]        t_b_in,
   input  logic [CNU_NUM*CN_DEG*QUAN_SIZE-1:0] v2c_in,
   output logic                                out_valid,
   output logic [FRAME_W-1:0]                  out_frame,
   output logic [CNU_NUM*QUAN_SIZE-1:0]        t_a_out,
   output logic [CNU_NUM*QUAN_SIZE-1:0]        t_b_out,
   output logic [CNU_NUM*CN_DEG*QUAN_SIZE-1:0] v2c_out,
   input  logic                                upd_start,
   input  logic [FRAME_W-1:0]                  upd_frame,
   input  logic                                upd_we,
   input  logic [QUAN_SIZE-1:0]                upd_data,
   output logic                                upd_busy,
   output logic                                upd_done,
   output logic [MULTI_FRAME_NUM-1:0]          lut_loaded,
   output logic                                frame_err
);
   localparam int STAGES    = PIPELINE_DEPTH;
   localparam int ADDR_W    = 2 * QUAN_SIZE;
   localparam int LUT_DEPTH = 2 ** (FRAME_W + ADDR_W);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic {IDLE, LOAD} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q;
   logic [FRAME_W-1:0]  frame_q;
   logic                lut_we, last_wr, load_go, accept;

   // LUT storage: {frame, t, v2c} addressing. Contents are not reset.
   logic [QUAN_SIZE-1:0] lut [LUT_DEPTH];

   // ---------------- update FSM ----------------
   always_comb begin
      state_d  = state_q;
      lut_we   = 1'b0;
      last_wr  = 1'b0;
      in_ready = 1'b0;
      upd_busy = 1'b0;
      load_go  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (upd_start) begin
               load_go = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
            upd_busy = 1'b1;
            if (upd_we) begin
               lut_we = 1'b1;
               if (cnt_q == '1) begin
                  last_wr = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         frame_q    <= '0;
         lut_loaded <= '0;
         upd_done   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         upd_done <= last_wr;
         if (load_go) begin
            frame_q               <= upd_frame;
            cnt_q                 <= '0;
            lut_loaded[upd_frame] <= 1'b0;
         end
         if (lut_we) cnt_q <= cnt_q + ADDR_ONE;
         if (last_wr) lut_loaded[frame_q] <= 1'b1;
         // Checked against the flag before any clear in this same cycle,
         // matching the old-contents lookup the sample actually gets.
         if (accept && !lut_loaded[in_frame]) frame_err <= 1'b1;
      end
   end

   // Writes only happen in LOAD, reads only matter in IDLE, so no port conflict.
   always_ff @(posedge read_clk) begin
      if (lut_we) lut[{frame_q, cnt_q}] <= upd_data;
   end

   // ---------------- valid pipeline ----------------
   logic [STAGES:1] vld_pipe;
   logic [STAGES:1] stage_en;

   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= accept;
         for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_comb begin
      stage_en    = '0;
      stage_en[1] = accept;
      for (int i = 2; i <= STAGES; i++) stage_en[i] = vld_pipe[i-1];
   end

   assign out_valid = vld_pipe[STAGES];

   // Frame tag rides the same enables as the data.
   logic [STAGES:1][FRAME_W-1:0] fr_q;
   logic [STAGES:1][FRAME_W-1:0] fr_in;

   always_comb begin
      fr_in    = '0;
      fr_in[1] = in_frame;
      for (int i = 2; i <= STAGES; i++) fr_in[i] = fr_q[i-1];
   end

   always_ff @(posedge read_clk or posedge rst) begin
      if (rst) begin
         fr_q <= '0;
      end else begin
         for (int i = 1; i <= STAGES; i++)
            if (stage_en[i]) fr_q[i] <= fr_in[i];
      end
   end

   assign out_frame = fr_q[STAGES];

   // ---------------- per-CNU lanes ----------------
   logic [CNU_NUM-1:0][QUAN_SIZE-1:0] lut_a, lut_b;

   for (genvar c = 0; c < CNU_NUM; c++) begin : g_cnu
      localparam int VA = (c * CN_DEG + SEL_A) * QUAN_SIZE;
      localparam int VB = (c * CN_DEG + SEL_B) * QUAN_SIZE;

      assign lut_a[c] = lut[{in_frame, t_a_in[c*QUAN_SIZE +: QUAN_SIZE], v2c_in[VA +: QUAN_SIZE]}];
      assign lut_b[c] = lut[{in_frame, t_b_in[c*QUAN_SIZE +: QUAN_SIZE], v2c_in[VB +: QUAN_SIZE]}];

      cnu_f1_lane #(
         .QUAN_SIZE (QUAN_SIZE),
         .CN_DEG    (CN_DEG),
         .STAGES    (STAGES)
      ) u_lane (
         .read_clk (read_clk),
         .rst      (rst),
         .stage_en (stage_en),
         .lut_a    (lut_a[c]),
         .lut_b    (lut_b[c]),
         .v2c      (v2c_in [c*CN_DEG*QUAN_SIZE +: CN_DEG*QUAN_SIZE]),
         .t_a      (t_a_out[c*QUAN_SIZE +: QUAN_SIZE]),
         .t_b      (t_b_out[c*QUAN_SIZE +: QUAN_SIZE]),
         .v2c_d    (v2c_out[c*CN_DEG*QUAN_SIZE +: CN_DEG*QUAN_SIZE])
      );
   end
endmodule

// File: doc/cnu_f1_multi.md
Name: cnu_f1_multi

Overview:
- Parametrised first-stage (F1) check-node datapath for the IB-LDPC decoder.
- Serves CNU_NUM check nodes of degree CN_DEG per cycle.
- Each CNU issues two IB-LUT lookups, address {t, v2c[sel]}, into an internal multi-frame symmetric CN LUT.
- Delays the full V2C vector so it arrives aligned with the lookup results for the F2 stage.
- The LUT is reloaded in place by an update FSM, with input backpressure while it runs.

Parameters:
- QUAN_SIZE, 4, message width in bits.
- CNU_NUM, 2, number of CNUs served in parallel.
- CN_DEG, 6, check-node degree (V2C messages per CNU).
- SEL_A, 2, V2C index paired with t_a.
- SEL_B, 5, V2C index paired with t_b.
- PIPELINE_DEPTH, 3, input-to-output latency in cycles; legal range 1..8.
- MULTI_FRAME_NUM, 2, number of LUT frames.
- FRAME_W, 1, frame-select width; equals clog2(MULTI_FRAME_NUM).

Ports:
- read_clk  in  1  single clock; datapath, LUT read and LUT write all use it.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input; high only in IDLE.
- in_frame  in  FRAME_W  LUT frame for this sample (multi-frame offset).
- t_a_in  in  CNU_NUM*QUAN_SIZE  first partial-t per CNU; CNU c at slice c.
- t_b_in  in  CNU_NUM*QUAN_SIZE  second partial-t per CNU.
- v2c_in  in  CNU_NUM*CN_DEG*QUAN_SIZE  V2C messages; CNU c, edge e at slice c*CN_DEG+e.
- out_valid  out  1  output valid.
- out_frame  out  FRAME_W  forwarded in_frame.
- t_a_out  out  CNU_NUM*QUAN_SIZE  LUT[frame][{t_a, v2c[SEL_A]}].
- t_b_out  out  CNU_NUM*QUAN_SIZE  LUT[frame][{t_b, v2c[SEL_B]}].
- v2c_out  out  CNU_NUM*CN_DEG*QUAN_SIZE  delayed copy of v2c_in.
- upd_start  in  1  request reload of upd_frame.
- upd_frame  in  FRAME_W  frame to reload.
- upd_we  in  1  one LUT word valid on upd_data.
- upd_data  in  QUAN_SIZE  LUT word.
- upd_busy  out  1  high in LOAD.
- upd_done  out  1  one-cycle pulse at the end of a load.
- lut_loaded  out  MULTI_FRAME_NUM  per-frame "fully written" flag.
- frame_err  out  1  sticky: a sample was accepted on an unloaded frame.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; in_ready=1.
  - out_valid, out_frame, t_a_out, t_b_out, v2c_out, upd_busy, upd_done, lut_loaded, frame_err all 0.
  - Pipeline valid bits cleared. LUT array contents are not reset.
- LUT organisation and read:
  - MULTI_FRAME_NUM x 2^(2*QUAN_SIZE) words of QUAN_SIZE bits.
  - Entry address = {t (MSBs), v2c (LSBs)}.
  - 2*CNU_NUM read ports, read synchronously in the acceptance cycle.
- Accept condition: in_valid && in_ready.
- Latency:
  - A sample accepted at cycle k appears at k+PIPELINE_DEPTH with out_valid=1.
  - t outputs: one LUT register stage plus PIPELINE_DEPTH-1 delay stages.
  - v2c_out and out_frame: PIPELINE_DEPTH delay stages, aligned with t outputs.
  - Non-accepted cycles insert bubbles (out_valid=0); output data holds its last value.
- The pipeline is free-running and has no output backpressure.
- FSM IDLE:
  - in_ready=1.
  - upd_start -> LOAD next cycle; latch upd_frame; clear word counter; clear lut_loaded[upd_frame].
  - A sample accepted in the same cycle as upd_start is looked up with the old contents.
- FSM LOAD:
  - in_ready=0, upd_busy=1.
  - Each upd_we writes upd_data to LUT[latched frame][counter], then the counter increments.
  - When upd_we writes address 2^(2*QUAN_SIZE)-1: lut_loaded[frame] set, upd_done pulses, FSM returns to IDLE next cycle.
  - upd_start is ignored in LOAD.
  - upd_we is ignored in IDLE.
- In-flight samples drain normally during LOAD; they were already looked up.
- Frames not being loaded keep their contents and lut_loaded flag.
- frame_err: set when a sample is accepted with lut_loaded[in_frame]=0. It stays set until rst. The sample is still processed; its output data is the uninitialised LUT value.
- Reset during LOAD: FSM returns to IDLE, all lut_loaded bits cleared, partial frame contents undefined.

Test Plan:
- Load frame 0 (QUAN_SIZE=4) with word[i] = i[3:0] ^ i[7:4] over 256 upd_we cycles:
  - upd_busy=1 throughout LOAD.
  - upd_done pulses exactly once, one cycle after the 256th write.
  - lut_loaded=2'b01; in_ready returns to 1.
- With frame 0 loaded, send CNU0 t_a=3, v2c[2]=9, t_b=7, v2c[5]=1; frame 0; PIPELINE_DEPTH=3:
  - out_valid 3 cycles later.
  - t_a_out slice0=0xA (3^9), t_b_out slice0=0x6 (7^1).
  - v2c_out equals the input vector.
- Back-to-back samples for 10 cycles with in_valid toggling 1,0,1,1,... -> out_valid reproduces the same pattern delayed 3 cycles; data order preserved.
- Load frame 1 with all 0xF, then send alternating frames 0 and 1:
  - out_frame is forwarded with each sample.
  - Frame-1 results are 0xF; frame-0 results are unchanged.
- Assert in_valid and upd_start in the same cycle:
  - That sample is accepted and uses old contents.
  - in_ready=0 the next cycle.
  - in_valid is then held for 5 cycles in LOAD -> no acceptance, no out_valid for those cycles.
- Accept a sample on frame 1 before frame 1 is loaded -> frame_err=1 and it stays 1. Assert rst mid-LOAD (after 100 writes) -> all outputs 0, lut_loaded=0, FSM in IDLE, in_ready=1.
